// File: rtl/qdi_1of4_tx_stream.sv
// rtl/qdi_1of4_tx_stream.sv - synchronous FIFO feeding a four-phase 1-of-4 QDI transmitter
module qdi_1of4_tx_stream #(
    parameter int DW          = 64,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [2*DW-1:0]          Tx,
    input  logic [DW/2-1:0]          Txe,
    output logic                     busy,
    output logic [CNT_W-1:0]         tx_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int ND = DW / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    // Each 2-bit digit becomes a one-hot nibble on its four rails.
    function automatic logic [2*DW-1:0] encode_1of4(input logic [DW-1:0] v);
        logic [2*DW-1:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'b0001 << v[2*k +: 2];
        end
        return r;
    endfunction

    logic [ND-1:0]     sync_q [SYNC_STAGES];
    logic [ND-1:0]     txe_s;
    logic              txe_all_hi;
    logic              txe_all_lo;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic              push;
    logic              pop;

    state_t            state_q, state_d;
    logic [2*DW-1:0]   tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Txe is asynchronous to CLK: bring every bit through a plain flop chain
    // before the FSM looks at it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= Txe;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign txe_s      = sync_q[SYNC_STAGES-1];
    assign txe_all_hi = &txe_s;
    assign txe_all_lo = ~|txe_s;

    assign push = in_valid && ready_q;

    // Payload storage; contents are meaningless once the pointers are reset,
    // so the array itself needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO bookkeeping; in_ready is registered so it stays low through reset
    // and rises on the first edge afterwards.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        ready_d = (level_d < LW'(DEPTH));
    end

    // Handshake FSM: IDLE waits for data and a ready receiver, DATA holds the
    // codeword until every digit is acknowledged, NULL holds zero until every
    // digit re-enables. Mixed enable patterns never move the FSM.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((level_q != '0) && txe_all_hi) begin
                    state_d = S_DATA;
                    tx_d    = encode_1of4(mem_q[rd_ptr_q]);
                end
            end
            S_DATA: begin
                if (txe_all_lo) begin
                    state_d = S_NULL;
                    tx_d    = '0;
                    pop     = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_NULL: begin
                if (txe_all_hi) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = '0;
            end
        endcase
    end

    // State, rails, counter and FIFO pointers; reset discards any in-flight token.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            tx_q     <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    assign Tx         = tx_q;
    assign in_ready   = ready_q;
    assign tx_count   = cnt_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_qdi_1of4_tx_stream.sv
// tb/tb_qdi_1of4_tx_stream.sv - randomized self-checking bench for qdi_1of4_tx_stream
module tb_qdi_1of4_tx_stream;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CNT_W = 4;
    localparam int ND    = DW / 2;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [DW-1:0]           in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*DW-1:0]         Tx;
    logic [ND-1:0]           Txe;
    logic                    busy;
    logic [CNT_W-1:0]        tx_count;
    logic [$clog2(DEPTH):0]  fifo_level;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int model_cnt = 0;

    qdi_1of4_tx_stream #(
        .DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .Tx(Tx), .Txe(Txe), .busy(busy),
        .tx_count(tx_count), .fifo_level(fifo_level)
    );

    always #5 CLK = ~CLK;

    // Reference codeword: digit k of value d lights rail 4k+d.
    function automatic logic [2*DW-1:0] model_enc(input int tok);
        int r;
        r = 0;
        for (int k = 0; k < ND; k++) begin
            r = r + (1 << (4*k + ((tok / (1 << (2*k))) % 4)));
        end
        return (2*DW)'(r);
    endfunction

    function automatic int model_count();
        return model_cnt % (1 << CNT_W);
    endfunction

    // Offer one token for one edge; starts and ends on a falling edge.
    task automatic push_tok(input int tok, output bit acc);
        in_data  = DW'(tok);
        in_valid = 1'b1;
        acc      = in_ready;
        @(negedge CLK);
        in_valid = 1'b0;
        if (acc) exp_q.push_back(tok);
    endtask

    // Behave as the receiver for one token: see it, acknowledge, re-enable.
    task automatic rx_one();
        int tok;
        int n;
        logic [2*DW-1:0] seen;
        if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL rx_queue: no token expected but receiver invoked");
            return;
        end
        tok = exp_q.pop_front();
        n = 0;
        while (Tx == '0 && n < 40) begin @(negedge CLK); n++; end
        checks++;
        if (Tx !== model_enc(tok)) begin
            errors++;
            $display("FAIL rx_data: got %b want %b", Tx, model_enc(tok));
        end
        seen = Tx;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        checks++;
        if (Tx !== seen) begin
            errors++;
            $display("FAIL rx_hold: got %b want %b", Tx, seen);
        end
        Txe = '0;
        n = 0;
        while (Tx != '0 && n < 20) begin @(negedge CLK); n++; end
        checks++;
        if (Tx !== '0) begin
            errors++;
            $display("FAIL rx_null: got %b want 0", Tx);
        end
        model_cnt++;
        checks++;
        if (tx_count !== CNT_W'(model_count())) begin
            errors++;
            $display("FAIL rx_count: got %0d want %0d", tx_count, model_count());
        end
        Txe = '1;
        repeat (SS + 1) @(negedge CLK);
        checks++;
        if (Tx !== '0) begin
            errors++;
            $display("FAIL null_hold: got %b want 0 before NULL completes", Tx);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({Tx, in_ready, busy, tx_count, fifo_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: Tx=%b rdy=%b busy=%b cnt=%0d lvl=%0d want all 0",
                     Tx, in_ready, busy, tx_count, fifo_level);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b want 0", in_ready);
        end
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_first_edge: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] want;
        want = model_enc(13);
        Txe = '1;
        repeat (SS + 1) @(negedge CLK);
        in_data  = 4'b1101;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        checks++;
        if (Tx !== '0 || fifo_level !== 1) begin
            errors++;
            $display("FAIL basic_first_edge: Tx=%b lvl=%0d want 0 and 1", Tx, fifo_level);
        end
        @(negedge CLK);
        checks++;
        if (Tx !== want) begin
            errors++;
            $display("FAIL basic_latency: got %b want %b", Tx, want);
        end
        Txe = '0;
        repeat (SS) @(negedge CLK);
        checks++;
        if (Tx !== want) begin
            errors++;
            $display("FAIL basic_sync_delay: got %b want %b", Tx, want);
        end
        @(negedge CLK);
        model_cnt++;
        checks++;
        if (Tx !== '0 || tx_count !== CNT_W'(model_count())) begin
            errors++;
            $display("FAIL basic_ack: Tx=%b cnt=%0d want 0 and %0d", Tx, tx_count, model_count());
        end
        Txe = '1;
        repeat (SS + 2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_fill();
        bit acc;
        int accepted;
        accepted = 0;
        Txe = '0;
        repeat (SS + 1) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            push_tok(int'($urandom_range(0, 15)), acc);
            if (acc) accepted++;
        end
        checks++;
        if (accepted != 4 || in_ready !== 1'b0 || fifo_level !== 4) begin
            errors++;
            $display("FAIL fill_full: acc=%0d rdy=%b lvl=%0d want 4 0 4", accepted, in_ready, fifo_level);
        end
        checks++;
        if (Tx !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_blocked: Tx=%b busy=%b want 0 and 1", Tx, busy);
        end
        Txe = '1;
        repeat (4) rx_one();
        checks++;
        if (fifo_level !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained: lvl=%0d rdy=%b want 0 and 1", fifo_level, in_ready);
        end
    endtask

    task automatic test_partial();
        bit acc;
        int n;
        int tok;
        bit stable;
        logic [2*DW-1:0] v;
        Txe = '1;
        push_tok(int'($urandom_range(0, 15)), acc);
        n = 0;
        while (Tx == '0 && n < 20) begin @(negedge CLK); n++; end
        tok = exp_q.pop_front();
        v = Tx;
        checks++;
        if (v !== model_enc(tok)) begin
            errors++;
            $display("FAIL partial_data: got %b want %b", v, model_enc(tok));
        end
        Txe = 2'b01;
        stable = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (Tx !== v) stable = 1'b0;
        end
        checks++;
        if (!stable || tx_count !== CNT_W'(model_count())) begin
            errors++;
            $display("FAIL partial_hold: Tx=%b cnt=%0d want %b and %0d", Tx, tx_count, v, model_count());
        end
        Txe = 2'b00;
        n = 0;
        while (Tx != '0 && n < 20) begin @(negedge CLK); n++; end
        model_cnt++;
        checks++;
        if (Tx !== '0 || tx_count !== CNT_W'(model_count())) begin
            errors++;
            $display("FAIL partial_release: Tx=%b cnt=%0d want 0 and %0d", Tx, tx_count, model_count());
        end
        Txe = '1;
        repeat (SS + 2) @(negedge CLK);
    endtask

    task automatic test_same_cycle();
        bit acc;
        int t3;
        Txe = '1;
        push_tok(int'($urandom_range(0, 15)), acc);
        push_tok(int'($urandom_range(0, 15)), acc);
        checks++;
        if (fifo_level !== 2 || Tx !== model_enc(exp_q[0])) begin
            errors++;
            $display("FAIL same_setup: lvl=%0d Tx=%b want 2 and %b", fifo_level, Tx, model_enc(exp_q[0]));
        end
        Txe = '0;
        repeat (SS) @(negedge CLK);
        t3 = int'($urandom_range(0, 15));
        in_data  = DW'(t3);
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(t3);
        model_cnt++;
        checks++;
        if (fifo_level !== 2 || Tx !== '0 || tx_count !== CNT_W'(model_count())) begin
            errors++;
            $display("FAIL same_push_pop: lvl=%0d Tx=%b cnt=%0d want 2 0 %0d",
                     fifo_level, Tx, tx_count, model_count());
        end
        Txe = '1;
        repeat (2) rx_one();
    endtask

    task automatic test_stream();
        bit acc;
        int n;
        for (int it = 0; it < 13; it++) begin
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) begin
                push_tok(int'($urandom_range(0, 15)), acc);
                checks++;
                if (!acc) begin
                    errors++;
                    $display("FAIL stream_accept: in_ready low with level %0d", fifo_level);
                end
            end
            while (exp_q.size() > 0) rx_one();
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || fifo_level !== 0) begin
            errors++;
            $display("FAIL stream_idle: busy=%b lvl=%0d want 0 and 0", busy, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int n;
        Txe = '1;
        push_tok(int'($urandom_range(0, 15)), acc);
        push_tok(int'($urandom_range(0, 15)), acc);
        n = 0;
        while (Tx == '0 && n < 20) begin @(negedge CLK); n++; end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({Tx, fifo_level, tx_count, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid: Tx=%b lvl=%0d cnt=%0d busy=%b rdy=%b want all 0",
                     Tx, fifo_level, tx_count, busy, in_ready);
        end
        exp_q.delete();
        model_cnt = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover: rdy=%b busy=%b want 1 and 0", in_ready, busy);
        end
        repeat (SS + 1) @(negedge CLK);
        push_tok(int'($urandom_range(0, 15)), acc);
        rx_one();
    endtask

    initial begin
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        Txe      = '1;
        test_reset();
        test_basic();
        test_fill();
        test_partial();
        test_same_cycle();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
